// File: rtl/bandai_mapper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bandai_mapper_pkg
// Purpose  : Shared FSM encoding, register map and knock helper for the mapper.
// Revision : 1.0 - initial release
// ============================================================================
package bandai_mapper_pkg;

   typedef enum logic [1:0] {
      ST_LOCK  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_OPEN  = 2'd2
   } fsm_state_t;

   localparam logic [7:0] REG_BANK0     = 8'hC0;
   localparam logic [7:0] REG_BANK1     = 8'hC1;
   localparam logic [7:0] REG_BANK2     = 8'hC2;
   localparam logic [7:0] REG_BANK3     = 8'hC3;
   localparam logic [7:0] REG_BYTE_MODE = 8'hCE;
   localparam logic [7:0] REG_RELOCK    = 8'hCF;

   localparam logic [7:0] RELOCK_KEY = 8'hA5;
   localparam int         NUM_BANKS  = 4;

   // Knock byte k lives at [8k+7:8k]; step 0 is the least significant byte.
   function automatic logic [7:0] knock_byte(input logic [31:0] seq, input logic [1:0] idx);
      return seq[{idx, 3'b000} +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bandai_unlock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : bandai_unlock_fsm
// Purpose  : Address-knock matcher, boot bitstream shifter, SO and LOCKED.
// Revision : 1.0 - initial release
// ============================================================================
module bandai_unlock_fsm
   import bandai_mapper_pkg::*;
#(
   parameter int                   UNLOCK_LEN = 2,
   parameter logic [31:0]          UNLOCK_SEQ = 32'h0000A55A,
   parameter int                   STREAM_W   = 18,
   parameter logic [STREAM_W-1:0]  STREAM     = 18'h05140
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_event,
   input  logic [7:0] i_addr,
   input  logic       i_relock,
   output logic       o_so,
   output logic       o_locked
);

   localparam int                CNT_W       = $clog2(STREAM_W + 1);
   localparam logic [1:0]        C_LAST_STEP = 2'(UNLOCK_LEN - 1);
   localparam logic [CNT_W-1:0]  C_LAST_BIT  = CNT_W'(STREAM_W - 1);

   fsm_state_t           r_state;
   logic [1:0]           r_step;
   logic [STREAM_W-1:0]  r_shift;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_locked;

   logic w_hit_cur;
   logic w_hit_first;

   assign w_hit_cur   = (i_addr == knock_byte(UNLOCK_SEQ, r_step));
   assign w_hit_first = (i_addr == knock_byte(UNLOCK_SEQ, 2'd0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_LOCK;
         r_step   <= 2'd0;
         r_shift  <= '1;
         r_cnt    <= '0;
         r_locked <= 1'b1;
      end else begin
         case (r_state)
            ST_LOCK: begin
               if (i_event) begin
                  if (w_hit_cur) begin
                     if (r_step == C_LAST_STEP) begin
                        r_state  <= ST_SHIFT;
                        r_step   <= 2'd0;
                        r_shift  <= STREAM;
                        r_cnt    <= '0;
                        r_locked <= 1'b0;
                     end else begin
                        r_step <= r_step + 2'd1;
                     end
                  end else if (w_hit_first) begin
                     // A mismatch that is itself the first knock restarts at step 1.
                     r_step <= 2'd1;
                  end else begin
                     r_step <= 2'd0;
                  end
               end
            end
            ST_SHIFT: begin
               if (i_relock) begin
                  r_state  <= ST_LOCK;
                  r_step   <= 2'd0;
                  r_shift  <= '1;
                  r_locked <= 1'b1;
               end else begin
                  r_shift <= {1'b1, r_shift[STREAM_W-1:1]};
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == C_LAST_BIT) begin
                     r_state <= ST_OPEN;
                  end
               end
            end
            ST_OPEN: begin
               if (i_relock) begin
                  r_state  <= ST_LOCK;
                  r_step   <= 2'd0;
                  r_shift  <= '1;
                  r_locked <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_LOCK;
               r_step   <= 2'd0;
               r_shift  <= '1;
               r_locked <= 1'b1;
            end
         endcase
      end
   end

   // The 1-fill keeps SO idle-high outside SHIFT without a separate mux.
   assign o_so     = r_shift[0];
   assign o_locked = r_locked;

endmodule
`default_nettype wire

// File: rtl/bandai_mapper_gen2.sv
`default_nettype none
// ============================================================================
// Module   : bandai_mapper_gen2
// Purpose  : Cartridge mapper: knock unlock, bank file, read path, CE decode.
//            Optional ROM byte mode (BYTEn port, register CE) via ROM_BYTE_MODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bandai_mapper_gen2
   import bandai_mapper_pkg::*;
#(
   parameter int                   RADDR_W    = 7,
   parameter int                   UNLOCK_LEN = 2,
   parameter logic [31:0]          UNLOCK_SEQ = 32'h0000A55A,
   parameter int                   STREAM_W   = 18,
   parameter logic [STREAM_W-1:0]  STREAM     = 18'h05140
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CEn,
   input  logic               WEn,
   input  logic               OEn,
   input  logic               SSn,
   input  logic [7:0]         ADDR,
   input  logic [7:0]         DQ_I,
   output logic [7:0]         DQ_O,
   output logic               DQ_OE,
   output logic               SO,
   output logic               ROMCEn,
   output logic               RAMCEn,
   output logic [RADDR_W-1:0] RADDR,
`ifdef ROM_BYTE_MODE_EN
   output logic               BYTEn,
`endif
   output logic               LOCKED
);

   logic       r_cen;
   logic       r_wen;
   logic       r_wen_d;
   logic       r_oen;
   logic       r_ssn;
   logic [7:0] r_addr;
   logic [7:0] r_addr_d;
   logic [7:0] r_dq;

   logic [7:0] r_bank [NUM_BANKS];
   logic       r_dq_oe;
   logic [7:0] r_dq_o;

   logic       w_event;
   logic       w_sel;
   logic       w_write;
   logic       w_bank_hit;
   logic       w_relock;
   logic       w_read;
   logic       w_locked;
   logic       w_so;
   logic       w_byte_mode;
   logic [3:0] w_page;
   logic       w_rce;
   logic       w_ram_sel;
   logic       w_rom_sel;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cen    <= 1'b1;
         r_wen    <= 1'b1;
         r_wen_d  <= 1'b1;
         r_oen    <= 1'b1;
         r_ssn    <= 1'b1;
         r_addr   <= 8'h00;
         r_addr_d <= 8'h00;
         r_dq     <= 8'h00;
      end else begin
         r_cen    <= CEn;
         r_wen    <= WEn;
         r_wen_d  <= r_wen;
         r_oen    <= OEn;
         r_ssn    <= SSn;
         r_addr   <= ADDR;
         r_addr_d <= r_addr;
         r_dq     <= DQ_I;
      end
   end

   assign w_event    = (r_addr != r_addr_d);
   assign w_sel      = ~(r_ssn & r_cen);
   assign w_write    = ~r_wen_d & r_wen & w_sel;
   assign w_bank_hit = (r_addr[7:2] == REG_BANK0[7:2]);
   assign w_relock   = w_write & (r_addr == REG_RELOCK) & (r_dq == RELOCK_KEY);
   assign w_read     = ~r_oen & r_wen & w_sel & w_bank_hit & ~w_locked;

   bandai_unlock_fsm #(
      .UNLOCK_LEN (UNLOCK_LEN),
      .UNLOCK_SEQ (UNLOCK_SEQ),
      .STREAM_W   (STREAM_W),
      .STREAM     (STREAM)
   ) u_unlock (
      .clk      (CLK),
      .rst      (RST),
      .i_event  (w_event),
      .i_addr   (r_addr),
      .i_relock (w_relock),
      .o_so     (w_so),
      .o_locked (w_locked)
   );

   // LOCKED is the registered value, so a write landing with the final knock is dropped.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            r_bank[i] <= 8'hFF;
         end
      end else if (w_write & w_bank_hit & ~w_locked) begin
         r_bank[r_addr[1:0]] <= r_dq;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_dq_oe <= 1'b0;
         r_dq_o  <= 8'h00;
      end else begin
         r_dq_oe <= w_read;
         r_dq_o  <= w_read ? r_bank[r_addr[1:0]] : 8'h00;
      end
   end

`ifdef ROM_BYTE_MODE_EN
   logic r_byte_n;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_byte_n <= 1'b1;
      end else if (w_write & (r_addr == REG_BYTE_MODE) & ~w_locked) begin
         r_byte_n <= ~r_dq[0];
      end
   end

   assign BYTEn       = r_byte_n;
   assign w_byte_mode = ~r_byte_n;
`else
   assign w_byte_mode = 1'b0;
`endif

   // Decode uses the raw bus so the chip-selects follow the pins without a cycle of lag.
   assign w_page    = ADDR[7:4];
   assign w_rce     = ~w_locked & SSn & ~CEn;
   assign w_ram_sel = w_rce & ~w_byte_mode & (w_page == 4'd1);
   assign w_rom_sel = w_rce & (w_byte_mode ? (w_page >= 4'd1) : (w_page > 4'd1));

   always_comb begin
      RADDR = '0;
      if (w_ram_sel | w_rom_sel) begin
         if (w_page > 4'd3) begin
            RADDR = {r_bank[0][RADDR_W-5:0], w_page};
         end else begin
            RADDR = r_bank[ADDR[5:4]][RADDR_W-1:0];
         end
      end
   end

   assign RAMCEn = ~w_ram_sel;
   assign ROMCEn = ~w_rom_sel;
   assign DQ_OE  = r_dq_oe;
   assign DQ_O   = r_dq_o;
   assign SO     = w_so;
   assign LOCKED = w_locked;

endmodule
`default_nettype wire
